led_pwm_fader: RTL and testbench

Downstream output stage for the 16-LED walking pattern. It accepts a new LED on/off pattern through a valid/ready handshake and drives the physical LED pins with per-LED PWM. Each LED fades linearly toward its new brightness instead of switching hard. It sits between the pattern generator and the board LED pins, and is the toggle-rate-dominant load for the power-estimation runs.

---
 rtl/led_pwm_fader.sv | 173 +++++++++++++++++
 tb/tb_led_pwm_fader.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pwm_fader.sv
// led_pwm_fader: accepts LED on/off patterns over a valid/ready handshake and
// drives each LED with PWM, fading its brightness linearly toward the newly
// requested level. Prescaler, PWM counter and fade divider free-run.
module led_pwm_fader #(
    parameter int N_LEDS    = 16,
    parameter int PWM_BITS  = 8,
    parameter int PRESCALE  = 390,
    parameter int FADE_DIV  = 1,
    parameter int FADE_STEP = 1
) (
    input  logic                clk100m,
    input  logic                rst_n,
    input  logic [N_LEDS-1:0]   pattern_in,
    input  logic                pattern_valid,
    output logic                pattern_ready,
    input  logic [PWM_BITS-1:0] max_level,
    output logic [N_LEDS-1:0]   leds_out,
    output logic                busy
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int FD_W  = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        FADING = 1'b1
    } state_t;

    state_t              state_reg;
    logic                ready_reg;
    logic                busy_reg;
    logic [PRE_W-1:0]    pre_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [FD_W-1:0]     fade_cnt;
    logic [N_LEDS-1:0]   leds_reg;
    logic [N_LEDS-1:0]   led_on;
    logic [N_LEDS-1:0]   settled;

    logic tick;
    logic frame_end;
    logic fade_step;
    logic accept;
    logic all_settled;

    assign tick        = (pre_cnt == PRE_W'(PRESCALE - 1));
    assign frame_end   = tick && (pwm_cnt == {PWM_BITS{1'b1}});
    assign fade_step   = frame_end && (fade_cnt == FD_W'(FADE_DIV - 1));
    assign accept      = pattern_valid && ready_reg;
    assign all_settled = &settled;

    // Prescaler: wraps every PRESCALE cycles, tick marks the last cycle.
    always_ff @(posedge clk100m or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

    // PWM counter advances once per prescaler tick and wraps naturally.
    always_ff @(posedge clk100m or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
        end else if (tick) begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
        end
    end

    // Fade divider counts PWM frames; a fade step fires on its last count.
    always_ff @(posedge clk100m or negedge rst_n) begin
        if (!rst_n) begin
            fade_cnt <= '0;
        end else if (frame_end) begin
            if (fade_cnt == FD_W'(FADE_DIV - 1)) begin
                fade_cnt <= '0;
            end else begin
                fade_cnt <= fade_cnt + FD_W'(1);
            end
        end
    end

    // Per-LED target/level registers and clamped fade arithmetic.
    for (genvar gi = 0; gi < N_LEDS; gi++) begin : g_led
        logic [PWM_BITS-1:0] target_reg;
        logic [PWM_BITS-1:0] level_reg;
        logic [PWM_BITS-1:0] level_next;
        logic [PWM_BITS:0]   lvl_ext;
        logic [PWM_BITS:0]   tgt_ext;
        logic [PWM_BITS:0]   up_sum;
        logic [PWM_BITS:0]   down_lim;

        assign lvl_ext  = {1'b0, level_reg};
        assign tgt_ext  = {1'b0, target_reg};
        assign up_sum   = lvl_ext + (PWM_BITS + 1)'(FADE_STEP);
        assign down_lim = tgt_ext + (PWM_BITS + 1)'(FADE_STEP);

        // Move one step toward target, clamping so the target is never crossed.
        always_comb begin
            level_next = level_reg;
            if (lvl_ext < tgt_ext) begin
                level_next = (up_sum > tgt_ext) ? target_reg : up_sum[PWM_BITS-1:0];
            end else if (lvl_ext > tgt_ext) begin
                level_next = (lvl_ext < down_lim) ? target_reg
                                                  : level_reg - PWM_BITS'(FADE_STEP);
            end
        end

        // Target loads only at acceptance; level moves only on fade steps.
        always_ff @(posedge clk100m or negedge rst_n) begin
            if (!rst_n) begin
                target_reg <= '0;
                level_reg  <= '0;
            end else begin
                if (accept) begin
                    target_reg <= pattern_in[gi] ? max_level : '0;
                end
                if (fade_step) begin
                    level_reg <= level_next;
                end
            end
        end

        assign led_on[gi]  = (pwm_cnt < level_reg);
        assign settled[gi] = (level_reg == target_reg);
    end

    // Registered PWM outputs; level 0 never lights, 255 gives 255/256 duty.
    always_ff @(posedge clk100m or negedge rst_n) begin
        if (!rst_n) begin
            leds_reg <= '0;
        end else begin
            leds_reg <= led_on;
        end
    end

    // Handshake FSM with registered ready/busy flags.
    always_ff @(posedge clk100m or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            ready_reg <= 1'b1;
            busy_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        state_reg <= FADING;
                        ready_reg <= 1'b0;
                        busy_reg  <= 1'b1;
                    end
                end
                FADING: begin
                    if (all_settled) begin
                        state_reg <= IDLE;
                        ready_reg <= 1'b1;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    ready_reg <= 1'b1;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign pattern_ready = ready_reg;
    assign busy          = busy_reg;
    assign leds_out      = leds_reg;

endmodule

// File: tb/tb_led_pwm_fader.sv
// Directed testbench for led_pwm_fader using a short PWM frame
// (PRESCALE=2, 256 steps -> 512 cycles per frame, FADE_STEP=64).
module tb_led_pwm_fader;

    localparam int N = 16;

    logic        clk100m = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] pattern_in = '0;
    logic        pattern_valid = 1'b0;
    logic        pattern_ready;
    logic [7:0]  max_level = '0;
    logic [15:0] leds_out;
    logic        busy;

    int total = 0;
    int bad = 0;
    int duty [N];

    logic [7:0] lvl_mon [N];

    led_pwm_fader #(
        .N_LEDS(16), .PWM_BITS(8), .PRESCALE(2), .FADE_DIV(1), .FADE_STEP(64)
    ) dut (
        .clk100m(clk100m),
        .rst_n(rst_n),
        .pattern_in(pattern_in),
        .pattern_valid(pattern_valid),
        .pattern_ready(pattern_ready),
        .max_level(max_level),
        .leds_out(leds_out),
        .busy(busy)
    );

    always #5 clk100m = ~clk100m;

    for (genvar gi = 0; gi < N; gi++) begin : g_mon
        assign lvl_mon[gi] = dut.g_led[gi].level_reg;
    end

    task automatic step;
        @(posedge clk100m);
        #1;
    endtask

    task automatic check_idle(input string name);
        total++;
        if (pattern_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s: ready=%b busy=%b required ready=1 busy=0", name, pattern_ready, busy);
        end
    endtask

    task automatic do_accept(input logic [15:0] pat, input logic [7:0] lvl, input string name);
        int n;
        n = 0;
        pattern_in = pat;
        max_level = lvl;
        pattern_valid = 1'b1;
        while (pattern_ready !== 1'b1 && n < 5000) begin
            step;
            n++;
        end
        total++;
        if (pattern_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s_ready_wait: ready=%b required 1", name, pattern_ready);
        end
        step;
        pattern_valid = 1'b0;
        total++;
        if (pattern_ready !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL %s_accept: ready=%b busy=%b required ready=0 busy=1", name, pattern_ready, busy);
        end
        $display("accept %s: pattern=%h max_level=%h", name, pat, lvl);
    endtask

    task automatic wait_level(input int led, input logic [7:0] exp, input string name);
        logic [7:0] old;
        int n;
        old = lvl_mon[led];
        n = 0;
        while (lvl_mon[led] === old && n < 1200) begin
            step;
            n++;
        end
        total++;
        if (lvl_mon[led] !== exp) begin
            bad++;
            $display("FAIL %s: level[%0d]=%0d required %0d", name, led, lvl_mon[led], exp);
        end else begin
            $display("fade %s: level[%0d]=%0d", name, led, lvl_mon[led]);
        end
    endtask

    task automatic measure_duty;
        for (int i = 0; i < N; i++) duty[i] = 0;
        repeat (512) begin
            step;
            for (int i = 0; i < N; i++) if (leds_out[i]) duty[i]++;
        end
    endtask

    task automatic check_duty(input int led, input int exp, input string name);
        total++;
        if (duty[led] != exp) begin
            bad++;
            $display("FAIL %s: duty[%0d]=%0d/512 required %0d", name, led, duty[led], exp);
        end
    endtask

    task automatic check_level(input int led, input logic [7:0] exp, input string name);
        total++;
        if (lvl_mon[led] !== exp) begin
            bad++;
            $display("FAIL %s: level[%0d]=%0d required %0d", name, led, lvl_mon[led], exp);
        end
    endtask

    task automatic test_reset;
        step;
        step;
        total++;
        if (leds_out !== 16'h0000) begin
            bad++;
            $display("FAIL reset_leds: leds_out=%h required 0000", leds_out);
        end
        check_idle("reset_in");
        #2 rst_n = 1'b1;
        step;
        check_idle("reset_released");
        $display("reset: leds_out=%h ready=%b busy=%b", leds_out, pattern_ready, busy);
    endtask

    task automatic test_fade_in;
        int others;
        do_accept(16'h0001, 8'h80, "fade_in");
        wait_level(0, 8'd64, "fade_in_step1");
        total++;
        if (dut.pwm_cnt !== 8'd0) begin
            bad++;
            $display("FAIL fade_in_frame_edge: pwm_cnt=%0d required 0", dut.pwm_cnt);
        end
        total++;
        if (pattern_ready !== 1'b0) begin
            bad++;
            $display("FAIL fade_in_mid_ready: ready=%b required 0", pattern_ready);
        end
        wait_level(0, 8'd128, "fade_in_step2");
        step;
        check_idle("fade_in_done");
        measure_duty;
        check_duty(0, 256, "fade_in_duty0");
        others = 0;
        for (int i = 1; i < N; i++) others += duty[i];
        total++;
        if (others != 0) begin
            bad++;
            $display("FAIL fade_in_others: high cycles on bits 15:1=%0d required 0", others);
        end
    endtask

    task automatic test_crossfade;
        do_accept(16'h0002, 8'h80, "crossfade");
        wait_level(0, 8'd64, "crossfade_l0_a");
        check_level(1, 8'd64, "crossfade_l1_a");
        wait_level(0, 8'd0, "crossfade_l0_b");
        check_level(1, 8'd128, "crossfade_l1_b");
        step;
        check_idle("crossfade_done");
        measure_duty;
        check_duty(0, 0, "crossfade_duty0");
        check_duty(1, 256, "crossfade_duty1");
    endtask

    task automatic test_back_to_back;
        int n;
        do_accept(16'h0001, 8'h80, "bp_first");
        pattern_in = 16'h0002;
        max_level = 8'h40;
        pattern_valid = 1'b1;
        n = 0;
        while (pattern_ready !== 1'b1 && n < 3000) begin
            step;
            n++;
        end
        total++;
        if (pattern_ready !== 1'b1 || lvl_mon[0] !== 8'd128 || lvl_mon[1] !== 8'd0 || n < 500) begin
            bad++;
            $display("FAIL bp_hold: ready=%b l0=%0d l1=%0d wait=%0d required ready=1 l0=128 l1=0 wait>=500",
                     pattern_ready, lvl_mon[0], lvl_mon[1], n);
        end
        step;
        pattern_valid = 1'b0;
        total++;
        if (pattern_ready !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL bp_accept: ready=%b busy=%b required ready=0 busy=1", pattern_ready, busy);
        end
        $display("accept bp_held: pattern=0002 max_level=40 after %0d held cycles", n);
        wait_level(0, 8'd64, "bp_l0_a");
        check_level(1, 8'd64, "bp_l1_a");
        wait_level(0, 8'd0, "bp_l0_b");
        check_level(1, 8'd64, "bp_l1_b");
        step;
        check_idle("bp_done");
        measure_duty;
        check_duty(1, 128, "bp_duty1");
        check_duty(0, 0, "bp_duty0");
    endtask

    task automatic test_saturation;
        logic [7:0] seq [4];
        seq[0] = 8'd64;
        seq[1] = 8'd128;
        seq[2] = 8'd192;
        seq[3] = 8'd255;
        do_accept(16'hFFFF, 8'hFF, "saturation");
        for (int k = 0; k < 4; k++) begin
            wait_level(0, seq[k], "sat_l0");
            check_level(15, seq[k], "sat_l15");
        end
        step;
        check_idle("sat_done");
        check_level(1, 8'd255, "sat_l1_final");
        measure_duty;
        for (int i = 0; i < N; i++) check_duty(i, 510, "sat_duty");
    endtask

    task automatic test_reset_mid_fade;
        int errs;
        do_accept(16'h0000, 8'h80, "reset_mid");
        wait_level(0, 8'd191, "reset_mid_down");
        repeat (100) step;
        total++;
        if (leds_out !== 16'hFFFF) begin
            bad++;
            $display("FAIL reset_mid_pre: leds_out=%h required ffff", leds_out);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (leds_out !== 16'h0000 || pattern_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_async: leds=%h ready=%b busy=%b required leds=0000 ready=1 busy=0",
                     leds_out, pattern_ready, busy);
        end
        step;
        step;
        #2 rst_n = 1'b1;
        errs = 0;
        repeat (600) begin
            step;
            if (leds_out !== 16'h0000 || busy !== 1'b0 || pattern_ready !== 1'b1) errs++;
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL reset_mid_after: bad cycles=%0d required 0", errs);
        end
        check_level(0, 8'd0, "reset_mid_level");
        $display("reset mid-fade: leds_out=%h ready=%b busy=%b", leds_out, pattern_ready, busy);
    endtask

    task automatic test_no_change;
        int errs;
        do_accept(16'h0000, 8'h80, "no_change");
        step;
        check_idle("no_change_one_cycle");
        errs = 0;
        repeat (600) begin
            step;
            if (leds_out !== 16'h0000) errs++;
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL no_change_leds: lit cycles=%0d required 0", errs);
        end
    endtask

    initial begin
        test_reset;
        test_fade_in;
        test_crossfade;
        test_back_to_back;
        test_saturation;
        test_reset_mid_fade;
        test_no_change;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
